// File: rtl/button_serial_front_end.sv
// button_serial_front_end: synchronize, debounce and edge-detect two buttons into a serial bit stream
module button_serial_front_end #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int WORD_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_level,
  output logic b_level,
  output logic bit_valid,
  output logic bit_value,
  output logic [$clog2(WORD_BITS)-1:0] bit_index,
  output logic word_done
);
  localparam int IW = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BITS - 1);
  logic a_s1, a_s2, b_s1, b_s2;
  logic a_level_d, b_level_d, pending_b;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  logic rise_a, rise_b;
  assign rise_a = a_level & ~a_level_d;
  assign rise_b = b_level & ~b_level_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      {a_s1, a_s2, b_s1, b_s2} <= '0;
      {a_level, b_level, a_level_d, b_level_d} <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
      pending_b <= 1'b0;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      bit_index <= '0;
      word_done <= 1'b0;
    end else begin
      {a_s2, a_s1} <= {a_s1, a_raw};
      {b_s2, b_s1} <= {b_s1, b_raw};
      a_cnt <= (a_s2 == a_level || a_cnt == CNT_LAST) ? '0 : a_cnt + 1'b1;
      b_cnt <= (b_s2 == b_level || b_cnt == CNT_LAST) ? '0 : b_cnt + 1'b1;
      if (a_s2 != a_level && a_cnt == CNT_LAST) a_level <= a_s2;
      if (b_s2 != b_level && b_cnt == CNT_LAST) b_level <= b_s2;
      a_level_d <= a_level;
      b_level_d <= b_level;
      // a simultaneous B rise is parked in pending_b and emitted the following cycle
      if (rise_a || rise_b || pending_b) begin
        bit_valid <= 1'b1;
        bit_value <= rise_a;
        pending_b <= rise_a ? (pending_b | rise_b) : 1'b0;
        word_done <= bit_index == IDX_LAST;
        bit_index <= bit_index == IDX_LAST ? '0 : bit_index + 1'b1;
      end else begin
        bit_valid <= 1'b0;
        word_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_button_serial_front_end.sv
// tb_button_serial_front_end: directed and random stimulus checked against a window/FIFO reference model
module tb_button_serial_front_end;
  localparam int DB = 4;
  localparam int WB = 4;
  logic clk = 1'b0, rst = 1'b0, a_raw = 1'b0, b_raw = 1'b0;
  logic a_level, b_level, bit_valid, bit_value, word_done;
  logic [1:0] bit_index;
  int total = 0, bad = 0, pulses = 0;
  bit m_s1a, m_s2a, m_s1b, m_s2b, m_la, m_lb, m_lad, m_lbd, m_val, m_vv, m_done;
  int m_cnt;
  bit wa[$], wb[$], fifo[$];

  button_serial_front_end dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
    .a_level(a_level), .b_level(b_level), .bit_valid(bit_valid),
    .bit_value(bit_value), .bit_index(bit_index), .word_done(word_done)
  );

  always #5 clk = ~clk;

  // a level flips once the last DB synchronized samples all disagree with it
  function automatic bit all_eq(input bit q[$], input bit v);
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit a, input bit b, input bit r);
    bit ra, rb;
    rst = r; a_raw = a; b_raw = b;
    @(posedge clk);
    if (!r) begin
      {m_s1a, m_s2a, m_s1b, m_s2b, m_la, m_lb, m_lad, m_lbd, m_val, m_vv, m_done} = '0;
      m_cnt = 0;
      fifo.delete(); wa.delete(); wb.delete();
    end else begin
      ra = m_la & !m_lad;
      rb = m_lb & !m_lbd;
      if (ra) fifo.push_back(1'b1);
      if (rb) fifo.push_back(1'b0);
      m_val = 1'b0;
      m_done = 1'b0;
      if (fifo.size() > 0) begin
        m_val = 1'b1;
        m_vv = fifo.pop_front();
        m_cnt++;
        m_done = (m_cnt % WB) == 0;
      end
      m_lad = m_la;
      m_lbd = m_lb;
      wa.push_back(m_s2a);
      wb.push_back(m_s2b);
      if (wa.size() > DB) void'(wa.pop_front());
      if (wb.size() > DB) void'(wb.pop_front());
      if (wa.size() == DB && all_eq(wa, !m_la)) m_la = !m_la;
      if (wb.size() == DB && all_eq(wb, !m_lb)) m_lb = !m_lb;
      m_s2a = m_s1a; m_s1a = a;
      m_s2b = m_s1b; m_s1b = b;
    end
    #1;
    total++;
    assert ({a_level, b_level, bit_valid, bit_value, bit_index, word_done} ===
            {m_la, m_lb, m_val, m_vv, 2'(m_cnt % WB), m_done})
    else begin
      bad++;
      $error("FAIL cycle t=%0t obs(al,bl,v,val,idx,done)=%b exp=%b", $time,
             {a_level, b_level, bit_valid, bit_value, bit_index, word_done},
             {m_la, m_lb, m_val, m_vv, 2'(m_cnt % WB), m_done});
    end
    if (bit_valid === 1'b1) pulses++;
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b1);
  endtask

  task automatic expect_pulses(input int n, input string tag);
    total++;
    assert (pulses === n)
    else begin
      bad++;
      $error("FAIL %s pulses obs=%0d exp=%0d", tag, pulses, n);
    end
    pulses = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    pulses = 0;
    hold(1'b1, 1'b1, 12);
    expect_pulses(2, "reset_held");
    hold(1'b0, 1'b0, 10);
    expect_pulses(0, "release_both");
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 10);
    expect_pulses(1, "clean_a");
    for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 10);
    expect_pulses(1, "bounce");
    hold(1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 10);
    expect_pulses(0, "glitch_b");
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    expect_pulses(2, "simultaneous");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      hold(i == 0 || i >= 3, i == 1 || i == 2, 8);
      hold(1'b0, 1'b0, 8);
    end
    expect_pulses(5, "word_wrap");
    for (int s = 0; s < 300; s++) begin
      bit r, a, b;
      int n;
      r = $urandom_range(0, 40) != 0;
      a = 1'($urandom);
      b = 1'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) step(a, b, r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_serial_front_end.md
Name: button_serial_front_end

Overview:
- Front-end stage that sits directly upstream of the 4-bit serial input register and the two-press majority FSM.
- Conditions two raw, asynchronous push-button inputs (a, b): 2-flop synchronize, debounce, then detect rising edges.
- Converts each clean press into exactly one serial bit plus a one-cycle valid strobe: press on a gives 1, press on b gives 0.
- Tracks position within the 4-bit word and flags word completion, so the downstream shift register and FSM never see glitches, duplicate edges or lost simultaneous presses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clk cycles a synchronized input must differ from its stable level before the stable level changes. Legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter. Derived; not overridden.
- WORD_BITS, 4: number of serial bits per word. Must match the downstream register depth.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset. Sampled on posedge clk; while 0, all state is forced to its reset value.
- a_raw  in  1  raw button A, asynchronous, may bounce.
- b_raw  in  1  raw button B, asynchronous, may bounce.
- a_level  out  1  debounced stable level of A (registered).
- b_level  out  1  debounced stable level of B (registered).
- bit_valid  out  1  one-cycle strobe: a new serial bit is presented.
- bit_value  out  1  serial bit, meaningful only when bit_valid=1. 1 = A press, 0 = B press.
- bit_index  out  $clog2(WORD_BITS)  bits already emitted in the current word (0..WORD_BITS-1).
- word_done  out  1  one-cycle strobe, coincident with the bit_valid that completes a word.

Behaviour:
- Reset (rst=0 at a posedge): sync flops, a_level, b_level, debounce counters, edge-history flops, pending_b, bit_valid, bit_value, bit_index and word_done all become 0.
- Synchronizer: each raw input passes through 2 flops (s1, s2). Only s2 is used downstream.
- Debounce, per channel, each posedge:
  - if s2 == level: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: level <= s2, counter <= 0.
  - else: counter <= counter+1.
  - A bounce back to level at any point restarts the count from 0.
- Edge detect: rise_x = level_x & ~level_x_d, where level_x_d is level_x delayed by one cycle. Falling edges produce no bit.
- Latency: raw change captured into s1 at edge k → level changes at edge k+1+DEBOUNCE_CYCLES → bit_valid high for the cycle after edge k+2+DEBOUNCE_CYCLES.
- Output register, each posedge:
  - rise_a: bit_valid<=1, bit_value<=1.
  - else pending_b or rise_b: bit_valid<=1, bit_value<=0, pending_b<=0.
  - else: bit_valid<=0, bit_value holds.
- Simultaneous rise_a and rise_b in the same cycle:
  - emit A's 1 in that cycle and set pending_b;
  - B's 0 is emitted in the next cycle.
  - No press is dropped. DEBOUNCE_CYCLES>=2 guarantees no new rise while pending_b is set.
- Word tracking, on each emitted bit:
  - if bit_index == WORD_BITS-1: word_done<=1 (same cycle as bit_valid), bit_index<=0.
  - else: bit_index<=bit_index+1, word_done<=0.
  - When no bit is emitted, word_done<=0.
- Holding a button produces exactly one bit. Release produces none. A re-press requires release to be debounced first.
- Reset mid-debounce or with pending_b set:
  - pending events are discarded;
  - after reset is released, a button still held is seen as a new rise once debounced.
- Outputs are glitch-free registers; bit_valid is never high for 2 consecutive cycles except in the simultaneous-press case (two distinct bits).

Test Plan:
- Reset: rst=0 for 3 cycles with a_raw=b_raw=1 → all outputs 0. Release rst → one bit_valid with bit_value=1 on the 7th cycle after a_raw is first sampled (DEBOUNCE_CYCLES=4); b's 0 follows on the next cycle.
- Clean A press: a_raw 0→1 held 20 cycles → single bit_valid pulse, bit_value=1, a_level=1, bit_index 0→1. Release → no pulse, a_level→0 after 6 cycles.
- Bounce: a_raw toggles 1,0,1,0 every cycle for 8 cycles, then steady 1 → exactly one bit_valid, arriving 6 cycles after the last toggle.
- Glitch reject: b_raw high for 3 cycles only → no bit_valid, b_level stays 0.
- Simultaneous: a_raw and b_raw rise on the same edge → bit_valid for 2 consecutive cycles with values 1 then 0; bit_index advances by 2.
- Word wrap: presses A, B, B, A → bit values 1, 0, 0, 1. word_done=1 only with the 4th bit; bit_index returns to 0. A 5th press gives bit_index=1.
